// File: rtl/algo_1r2w_req_sched_pkg.sv
// Shared widths, read tag payload and helpers for the 1r2w requester scheduler.
package algo_1r2w_req_sched_pkg;

  localparam int unsigned NUMREQ   = 4;
  localparam int unsigned BITREQ   = 2;
  localparam int unsigned WIDTH    = 32;
  localparam int unsigned BITADDR  = 13;
  localparam int unsigned RD_DELAY = 4;
  localparam int unsigned RESP_LAT = RD_DELAY + 2;

  typedef logic [NUMREQ-1:0]         req_vec_t;
  typedef logic [NUMREQ*BITADDR-1:0] req_adr_t;
  typedef logic [NUMREQ*WIDTH-1:0]   req_dat_t;

  typedef struct packed {
    logic              vld;
    logic [BITREQ-1:0] id;
  } rd_tag_t;

  function automatic logic [BITREQ-1:0] rr_next(input logic [BITREQ-1:0] i);
    return BITREQ'((32'(i) + 32'd1) % NUMREQ);
  endfunction

  function automatic logic [BITADDR-1:0] adr_at(input req_adr_t a, input logic [BITREQ-1:0] i);
    return a[32'(i)*BITADDR +: BITADDR];
  endfunction

  function automatic logic [WIDTH-1:0] dat_at(input req_dat_t d, input logic [BITREQ-1:0] i);
    return d[32'(i)*WIDTH +: WIDTH];
  endfunction

endpackage

// File: rtl/algo_rr_pick.sv
// Round-robin find-first: first unmasked request scanning ptr, ptr+1, ... mod N.
module algo_rr_pick #(
  parameter int unsigned N = 4,
  parameter int unsigned B = 2
) (
  input  logic [N-1:0] req,
  input  logic [N-1:0] mask,
  input  logic [B-1:0] ptr,
  output logic         vld,
  output logic [B-1:0] idx
);

  logic [B-1:0] cand;

  always_comb begin
    vld  = 1'b0;
    idx  = ptr;
    cand = ptr;
    for (int unsigned k = 0; k < N; k++) begin
      cand = B'((32'(ptr) + k) % N);
      if (!vld && req[cand] && !mask[cand]) begin
        vld = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/algo_1r2w_req_sched.sv
// Arbitrates NUMREQ requesters onto one 2-write/1-read memory and routes
// read data back to the originating requester through a latency-matched tag pipe.
module algo_1r2w_req_sched
  import algo_1r2w_req_sched_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUMREQ-1:0]      rq_write,
  input  logic [NUMREQ*BITADDR-1:0] rq_wr_adr,
  input  logic [NUMREQ*WIDTH-1:0]   rq_din,
  output logic [NUMREQ-1:0]      rq_wr_gnt,
  input  logic [NUMREQ-1:0]      rq_read,
  input  logic [NUMREQ*BITADDR-1:0] rq_rd_adr,
  output logic [NUMREQ-1:0]      rq_rd_gnt,
  output logic [NUMREQ-1:0]      rq_rd_vld,
  output logic [WIDTH-1:0]       rq_rd_dout,
  output logic                   tag_err,
  input  logic                   ready,
  output logic [1:0]             write,
  output logic [2*BITADDR-1:0]   wr_adr,
  output logic [2*WIDTH-1:0]     din,
  output logic                   read,
  output logic [BITADDR-1:0]     rd_adr,
  input  logic                   rd_vld,
  input  logic [WIDTH-1:0]       rd_dout
);

  logic               active;
  req_vec_t           wr_req, rd_req, wr_eq;
  logic               w0_vld, w1_vld, r_vld, r_gnt, rd_conflict;
  logic [BITREQ-1:0]  w0_idx, w1_idx, r_idx, w1_ptr;
  logic [BITREQ-1:0]  wptr, rptr, rd_id;
  logic [BITADDR-1:0] w0_adr, w1_adr, r_adr;
  rd_tag_t            tag_q [RD_DELAY];
  rd_tag_t            tag_tail;

  assign active = ready & ~rst;
  assign wr_req = rq_write & {NUMREQ{active}};
  assign rd_req = rq_read & {NUMREQ{active}};

  algo_rr_pick #(.N(NUMREQ), .B(BITREQ)) u_wr0 (
    .req(wr_req), .mask('0), .ptr(wptr), .vld(w0_vld), .idx(w0_idx)
  );

  assign w0_adr = adr_at(rq_wr_adr, w0_idx);
  assign w1_ptr = rr_next(w0_idx);

  // Slot 1 excludes slot 0 and anything targeting the same address.
  always_comb begin
    wr_eq = '0;
    for (int unsigned i = 0; i < NUMREQ; i++)
      wr_eq[i] = (adr_at(rq_wr_adr, BITREQ'(i)) == w0_adr);
  end

  algo_rr_pick #(.N(NUMREQ), .B(BITREQ)) u_wr1 (
    .req(wr_req), .mask(wr_eq), .ptr(w1_ptr), .vld(w1_vld), .idx(w1_idx)
  );

  algo_rr_pick #(.N(NUMREQ), .B(BITREQ)) u_rd (
    .req(rd_req), .mask('0), .ptr(rptr), .vld(r_vld), .idx(r_idx)
  );

  assign w1_adr      = adr_at(rq_wr_adr, w1_idx);
  assign r_adr       = adr_at(rq_rd_adr, r_idx);
  // A read racing a same-address write waits so that its retry sees the new data.
  assign rd_conflict = (w0_vld && (r_adr == w0_adr)) || (w1_vld && (r_adr == w1_adr));
  assign r_gnt       = r_vld && !rd_conflict;

  always_comb begin
    rq_wr_gnt = '0;
    rq_rd_gnt = '0;
    if (w0_vld) rq_wr_gnt[w0_idx] = 1'b1;
    if (w1_vld) rq_wr_gnt[w1_idx] = 1'b1;
    if (r_gnt)  rq_rd_gnt[r_idx]  = 1'b1;
  end

  // Issue stage and round-robin pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      write  <= '0;
      wr_adr <= '0;
      din    <= '0;
      read   <= 1'b0;
      rd_adr <= '0;
      rd_id  <= '0;
      wptr   <= '0;
      rptr   <= '0;
    end else begin
      write <= {w1_vld, w0_vld};
      read  <= r_gnt;
      if (w0_vld) begin
        wr_adr[0 +: BITADDR] <= w0_adr;
        din[0 +: WIDTH]      <= dat_at(rq_din, w0_idx);
      end
      if (w1_vld) begin
        wr_adr[BITADDR +: BITADDR] <= w1_adr;
        din[WIDTH +: WIDTH]        <= dat_at(rq_din, w1_idx);
      end
      if (r_gnt) begin
        rd_adr <= r_adr;
        rd_id  <= r_idx;
        rptr   <= rr_next(r_idx);
      end
      if (w1_vld)      wptr <= rr_next(w1_idx);
      else if (w0_vld) wptr <= rr_next(w0_idx);
    end
  end

  assign tag_tail = tag_q[RD_DELAY-1];

  // Tag pipe tracks the issued read strobe so its tail lines up with rd_vld.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < RD_DELAY; k++) tag_q[k] <= '0;
      rq_rd_vld  <= '0;
      rq_rd_dout <= '0;
      tag_err    <= 1'b0;
    end else begin
      tag_q[0] <= '{vld: read, id: rd_id};
      for (int unsigned k = 1; k < RD_DELAY; k++) tag_q[k] <= tag_q[k-1];
      rq_rd_vld <= (rd_vld && tag_tail.vld) ? (NUMREQ'(1) << tag_tail.id) : '0;
      if (rd_vld && tag_tail.vld) rq_rd_dout <= rd_dout;
      if (rd_vld && !tag_tail.vld) tag_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_algo_1r2w_req_sched.sv
// Vector table for arbitration plus a memory model and response scoreboard.
module tb_algo_1r2w_req_sched;
  import algo_1r2w_req_sched_pkg::*;

  logic                      clk = 1'b0;
  logic                      rst = 1'b0;
  logic [NUMREQ-1:0]         rq_write = '0, rq_read = '0;
  logic [NUMREQ*BITADDR-1:0] rq_wr_adr = '0, rq_rd_adr = '0;
  logic [NUMREQ*WIDTH-1:0]   rq_din = '0;
  logic [NUMREQ-1:0]         rq_wr_gnt, rq_rd_gnt, rq_rd_vld;
  logic [WIDTH-1:0]          rq_rd_dout;
  logic                      tag_err;
  logic                      ready = 1'b0;
  logic [1:0]                write;
  logic [2*BITADDR-1:0]      wr_adr;
  logic [2*WIDTH-1:0]        din;
  logic                      read;
  logic [BITADDR-1:0]        rd_adr;
  logic                      rd_vld = 1'b0;
  logic [WIDTH-1:0]          rd_dout = '0;

  algo_1r2w_req_sched dut (
    .clk(clk), .rst(rst),
    .rq_write(rq_write), .rq_wr_adr(rq_wr_adr), .rq_din(rq_din), .rq_wr_gnt(rq_wr_gnt),
    .rq_read(rq_read), .rq_rd_adr(rq_rd_adr), .rq_rd_gnt(rq_rd_gnt),
    .rq_rd_vld(rq_rd_vld), .rq_rd_dout(rq_rd_dout), .tag_err(tag_err),
    .ready(ready), .write(write), .wr_adr(wr_adr), .din(din),
    .read(read), .rd_adr(rd_adr), .rd_vld(rd_vld), .rd_dout(rd_dout)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Memory model: writes land when strobed, reads answer RD_DELAY cycles later.
  bit [WIDTH-1:0] mem [1 << BITADDR];
  bit             resp_v [16];
  bit [WIDTH-1:0] resp_d [16];
  logic           inj = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) resp_v[i] = 1'b0;
      rd_vld = 1'b0;
    end else begin
      for (int p = 0; p < 2; p++)
        if (write[p]) mem[wr_adr[p*BITADDR +: BITADDR]] = din[p*WIDTH +: WIDTH];
      rd_vld  = resp_v[cyc % 16] | inj;
      rd_dout = resp_d[cyc % 16];
      resp_v[cyc % 16] = 1'b0;
      if (read) begin
        resp_v[(cyc + RD_DELAY) % 16] = 1'b1;
        resp_d[(cyc + RD_DELAY) % 16] = mem[rd_adr];
      end
    end
  end

  // Scoreboard: expected response pushed at read grant, checked on rq_rd_vld.
  typedef struct { int id; logic [WIDTH-1:0] dat; int due; } rsp_t;
  rsp_t           sb [$];
  bit [WIDTH-1:0] gold [1 << BITADDR];

  always @(negedge clk) begin : mon
    rsp_t e;
    if (!rst) begin
      for (int i = 0; i < NUMREQ; i++)
        if (rq_rd_gnt[i])
          sb.push_back('{id: i, dat: gold[rq_rd_adr[i*BITADDR +: BITADDR]], due: cyc + RESP_LAT});
      for (int i = 0; i < NUMREQ; i++)
        if (rq_wr_gnt[i]) gold[rq_wr_adr[i*BITADDR +: BITADDR]] = rq_din[i*WIDTH +: WIDTH];
      if (rq_rd_vld != '0) begin
        if (sb.size() == 0) chk("rsp_unexpected", 64'(rq_rd_vld), 64'(0));
        else begin
          e = sb.pop_front();
          chk("rsp_onehot", 64'(rq_rd_vld), 64'(4'(1) << e.id));
          chk("rsp_dout", 64'(rq_rd_dout), 64'(e.dat));
          chk("rsp_cycle", 64'(cyc), 64'(e.due));
        end
      end else if (sb.size() != 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        chk("rsp_missing", 64'(rq_rd_vld), 64'(4'(1) << e.id));
      end
    end
  end

  typedef struct {
    logic                   rdy;
    logic [3:0]             wr;
    logic [3:0][BITADDR-1:0] wa;
    logic [3:0]             rd;
    logic [3:0][BITADDR-1:0] ra;
    logic [3:0]             ewg;
    logic [3:0]             erg;
    logic [1:0]             ews;
    logic                   ers;
  } vec_t;

  localparam int NV = 19;
  vec_t tv [NV];

  function automatic vec_t mk(input logic rdy, input logic [3:0] wr, input int wb,
                              input logic [3:0] rd, input int rb, input logic [3:0] ewg,
                              input logic [3:0] erg, input logic [1:0] ews, input logic ers);
    vec_t v;
    v.rdy = rdy; v.wr = wr; v.rd = rd;
    v.ewg = ewg; v.erg = erg; v.ews = ews; v.ers = ers;
    for (int i = 0; i < 4; i++) begin
      v.wa[i] = BITADDR'(wb + i);
      v.ra[i] = BITADDR'(rb + i);
    end
    return v;
  endfunction

  task automatic apply(input vec_t v, input int k);
    ready = v.rdy; rq_write = v.wr; rq_read = v.rd;
    for (int i = 0; i < NUMREQ; i++) begin
      rq_wr_adr[i*BITADDR +: BITADDR] = v.wa[i];
      rq_rd_adr[i*BITADDR +: BITADDR] = v.ra[i];
      rq_din[i*WIDTH +: WIDTH] = 32'hA500_0000 | 32'(k << 8) | 32'(i);
    end
  endtask

  task automatic idle();
    rq_write = '0; rq_read = '0;
  endtask

  initial begin
    tv[0]  = mk(1, 4'b1111, 'h100, 4'b0000, 'h100, 4'b0011, 4'b0000, 2'b00, 0);
    tv[1]  = mk(1, 4'b1111, 'h100, 4'b0000, 'h100, 4'b1100, 4'b0000, 2'b11, 0);
    tv[2]  = mk(1, 4'b1111, 'h100, 4'b0000, 'h100, 4'b0011, 4'b0000, 2'b11, 0);
    tv[3]  = mk(1, 4'b1111, 'h100, 4'b0000, 'h100, 4'b1100, 4'b0000, 2'b11, 0);
    tv[4]  = mk(1, 4'b0110, 'h100, 4'b0000, 'h100, 4'b0010, 4'b0000, 2'b11, 0);
    tv[4].wa[1] = 13'h10; tv[4].wa[2] = 13'h10;
    tv[5]  = mk(1, 4'b0100, 'h100, 4'b0000, 'h100, 4'b0100, 4'b0000, 2'b01, 0);
    tv[5].wa[2] = 13'h10;
    tv[6]  = mk(1, 4'b0001, 'h300, 4'b1000, 'h300, 4'b0001, 4'b0000, 2'b01, 0);
    tv[6].wa[0] = 13'h20; tv[6].ra[3] = 13'h20;
    tv[7]  = mk(1, 4'b0000, 'h300, 4'b1000, 'h300, 4'b0000, 4'b1000, 2'b01, 0);
    tv[7].ra[3] = 13'h20;
    tv[8]  = mk(1, 4'b0000, 'h100, 4'b1111, 'h100, 4'b0000, 4'b0001, 2'b00, 1);
    tv[9]  = mk(1, 4'b0000, 'h100, 4'b1110, 'h100, 4'b0000, 4'b0010, 2'b00, 1);
    tv[10] = mk(1, 4'b0000, 'h100, 4'b1100, 'h100, 4'b0000, 4'b0100, 2'b00, 1);
    tv[11] = mk(1, 4'b0000, 'h100, 4'b1000, 'h100, 4'b0000, 4'b1000, 2'b00, 1);
    for (int k = 12; k < 17; k++)
      tv[k] = mk(0, 4'b1111, 'h100, 4'b1111, 'h100, 4'b0000, 4'b0000, 2'b00, k == 12);
    tv[17] = mk(1, 4'b1111, 'h100, 4'b1111, 'h200, 4'b0110, 4'b0001, 2'b00, 0);
    tv[18] = mk(1, 4'b1001, 'h100, 4'b1110, 'h200, 4'b1001, 4'b0010, 2'b11, 1);

    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_write", 64'(write), 64'(0));
    chk("rst_read", 64'(read), 64'(0));
    chk("rst_rq_rd_vld", 64'(rq_rd_vld), 64'(0));
    chk("rst_tag_err", 64'(tag_err), 64'(0));
    chk("rst_wr_adr", 64'(wr_adr), 64'(0));
    chk("rst_din", din, 64'(0));
    chk("rst_rd_adr", 64'(rd_adr), 64'(0));
    chk("rst_dout", 64'(rq_rd_dout), 64'(0));
    @(posedge clk); #1 rst = 1'b0;

    for (int k = 0; k < NV; k++) begin
      @(posedge clk); #1 apply(tv[k], k);
      @(negedge clk);
      chk($sformatf("v%0d_wr_gnt", k), 64'(rq_wr_gnt), 64'(tv[k].ewg));
      chk($sformatf("v%0d_rd_gnt", k), 64'(rq_rd_gnt), 64'(tv[k].erg));
      chk($sformatf("v%0d_write", k), 64'(write), 64'(tv[k].ews));
      chk($sformatf("v%0d_read", k), 64'(read), 64'(tv[k].ers));
    end

    @(posedge clk); #1 idle();
    repeat (12) @(negedge clk);
    chk("drain_pending", 64'(sb.size()), 64'(0));
    chk("pre_inj_tag_err", 64'(tag_err), 64'(0));

    // Spurious rd_vld with nothing in flight.
    @(posedge clk); #1 inj = 1'b1;
    @(posedge clk); #1 inj = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("tag_err_set", 64'(tag_err), 64'(1));
    chk("tag_err_no_rsp", 64'(rq_rd_vld), 64'(0));
    repeat (4) @(negedge clk);
    chk("tag_err_sticky", 64'(tag_err), 64'(1));

    // Reset while reads are in flight.
    @(posedge clk); #1 apply(tv[17], 30);
    @(posedge clk); #1 apply(tv[18], 31);
    @(posedge clk); #2 rst = 1'b1;
    #1;
    chk("arst_write", 64'(write), 64'(0));
    chk("arst_read", 64'(read), 64'(0));
    chk("arst_tag_err", 64'(tag_err), 64'(0));
    chk("arst_rq_rd_vld", 64'(rq_rd_vld), 64'(0));
    chk("arst_wr_gnt", 64'(rq_wr_gnt), 64'(0));
    chk("arst_rd_gnt", 64'(rq_rd_gnt), 64'(0));
    chk("arst_wr_adr", 64'(wr_adr), 64'(0));
    chk("arst_rd_adr", 64'(rd_adr), 64'(0));
    sb.delete();
    idle();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("post_rst_rd_vld", 64'(rq_rd_vld), 64'(0));
    end
    chk("post_rst_tag_err", 64'(tag_err), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
